// File: rtl/regfile_pkg.sv
// Shared helpers for the scoreboarded register file: byte-mask expansion,
// population count and address-width derivation.
package regfile_pkg;

  // Upper bounds for the helper functions; callers zero-extend and truncate.
  localparam int unsigned MAX_WIDTH = 1024;
  localparam int unsigned MAX_BE    = MAX_WIDTH / 8;
  localparam int unsigned MAX_DEPTH = 1024;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] byte_mask(input logic [MAX_BE-1:0] be);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < int'(MAX_BE); i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(MAX_DEPTH); i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register pending-write scoreboard: busy vector with flush > reserve >
// write-clear priority, plus a registered count of busy registers.
module regfile_scoreboard_bits
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              flush_i,
  output logic [DEPTH-1:0]  busy_o,
  output logic [ADDR_W:0]   busy_count_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  count_q, count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wr_en_i)  busy_d[wr_addr_i]  = 1'b0;
      // Applied after the clear so a same-edge reserve (new producer) wins.
      if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    count_d = (ADDR_W + 1)'(popcount(MAX_DEPTH'(busy_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with byte enables, optional write bypass,
// optional hardwired zero register and an integrated pending-write scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  A_addr,
  input  logic [ADDR_W-1:0]  B_addr,
  output logic [WIDTH-1:0]   A_data,
  output logic [WIDTH-1:0]   B_data,
  output logic               A_busy,
  output logic               B_busy,
  input  logic [ADDR_W-1:0]  W_addr,
  input  logic [WIDTH-1:0]   W_data,
  input  logic [WIDTH/8-1:0] W_be,
  input  logic               wr_enable,
  input  logic               rsv_enable,
  input  logic [ADDR_W-1:0]  rsv_addr,
  input  logic               flush,
  output logic [ADDR_W:0]    busy_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] w_mask;
  logic [DEPTH-1:0] busy;
  logic             w_to_zero;
  logic [WIDTH-1:0] rd_data [2];
  logic             rd_busy [2];

  assign w_mask    = WIDTH'(byte_mask(MAX_BE'(W_be)));
  assign w_to_zero = (ZERO_REG != 0) && (W_addr == '0);

  regfile_scoreboard_bits #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_bits (
    .clk          (clk),
    .rst_n        (reset),
    .rsv_en_i     (rsv_enable),
    .rsv_addr_i   (rsv_addr),
    .wr_en_i      (wr_enable),
    .wr_addr_i    (W_addr),
    .flush_i      (flush),
    .busy_o       (busy),
    .busy_count_o (busy_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is flops, not a RAM macro, so it can and must clear on reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_enable && !w_to_zero) begin
      mem_q[W_addr] <= (W_data & w_mask) | (mem_q[W_addr] & ~w_mask);
    end
  end

  // Bypass is gated by reset so a write in flight never leaks while reset is held.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic [ADDR_W-1:0] a;
      a          = (p == 0) ? A_addr : B_addr;
      rd_data[p] = mem_q[a];
      rd_busy[p] = busy[a];
      if ((ZERO_REG != 0) && (a == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if ((BYPASS != 0) && reset && wr_enable && (W_addr == a)) begin
        rd_data[p] = (W_data & w_mask) | (mem_q[a] & ~w_mask);
        rd_busy[p] = rsv_enable && (rsv_addr == a);
      end
    end
  end

  assign A_data = rd_data[0];
  assign B_data = rd_data[1];
  assign A_busy = rd_busy[0];
  assign B_busy = rd_busy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: two instances (bypass+zero-reg, and neither) driven in
// lockstep and compared against a register/busy-array reference model.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  A_addr, B_addr, W_addr, rsv_addr;
  logic [31:0] W_data;
  logic [3:0]  W_be;
  logic        wr_enable, rsv_enable, flush;

  logic [31:0] a0_data, b0_data, a1_data, b1_data;
  logic        a0_busy, b0_busy, a1_busy, b1_busy;
  logic [5:0]  c0, c1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .A_addr(A_addr), .B_addr(B_addr),
    .A_data(a0_data), .B_data(b0_data), .A_busy(a0_busy), .B_busy(b0_busy),
    .W_addr(W_addr), .W_data(W_data), .W_be(W_be), .wr_enable(wr_enable),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .flush(flush), .busy_count(c0)
  );

  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .A_addr(A_addr), .B_addr(B_addr),
    .A_data(a1_data), .B_data(b1_data), .A_busy(a1_busy), .B_busy(b1_busy),
    .W_addr(W_addr), .W_data(W_data), .W_be(W_be), .wr_enable(wr_enable),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .flush(flush), .busy_count(c1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instance 0 has zero register and bypass; instance 1 has neither.
  function automatic logic [31:0] exp_data(input int k, input logic [4:0] a);
    logic [31:0] r;
    r = m_mem[k][a];
    if (k == 0 && a == 0) return 32'd0;
    if (k == 0 && reset && wr_enable && W_addr == a)
      for (int b = 0; b < 4; b++) if (W_be[b]) r[8*b +: 8] = W_data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_busy(input int k, input logic [4:0] a);
    if (k == 0 && a == 0) return 32'd0;
    if (k == 0 && reset && wr_enable && W_addr == a)
      return {31'd0, rsv_enable && rsv_addr == a};
    return {31'd0, m_busy[k][a]};
  endfunction

  function automatic logic [31:0] exp_count(input int k);
    int n;
    n = 0;
    for (int r = 0; r < 32; r++) if (m_busy[k][r]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) begin
        m_mem[k][r]  = 32'd0;
        m_busy[k][r] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (!reset) return;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) begin
        logic is_zero;
        is_zero = (k == 0) && (r == 0);
        if (flush) m_busy[k][r] = 1'b0;
        else if (rsv_enable && rsv_addr == r && !is_zero) m_busy[k][r] = 1'b1;
        else if (wr_enable && W_addr == r) m_busy[k][r] = 1'b0;
        if (wr_enable && W_addr == r && !is_zero)
          for (int b = 0; b < 4; b++)
            if (W_be[b]) m_mem[k][r][8*b +: 8] = W_data[8*b +: 8];
      end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".A0d"}, a0_data, exp_data(0, A_addr));
    check({tag, ".B0d"}, b0_data, exp_data(0, B_addr));
    check({tag, ".A0b"}, {31'd0, a0_busy}, exp_busy(0, A_addr));
    check({tag, ".B0b"}, {31'd0, b0_busy}, exp_busy(0, B_addr));
    check({tag, ".C0"},  {26'd0, c0}, exp_count(0));
    check({tag, ".A1d"}, a1_data, exp_data(1, A_addr));
    check({tag, ".B1d"}, b1_data, exp_data(1, B_addr));
    check({tag, ".A1b"}, {31'd0, a1_busy}, exp_busy(1, A_addr));
    check({tag, ".B1b"}, {31'd0, b1_busy}, exp_busy(1, B_addr));
    check({tag, ".C1"},  {26'd0, c1}, exp_count(1));
  endtask

  // Called 1 time unit after a rising edge: check mid-cycle, then clock.
  task automatic cycle(input string tag);
    #3;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_enable = 1'b0; rsv_enable = 1'b0; flush = 1'b0; W_be = 4'h0;
  endtask

  initial begin
    reset = 1'b0; A_addr = '0; B_addr = '0; W_addr = '0; rsv_addr = '0;
    W_data = '0; idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_all("rst");

    // Reset dropped in the middle of a write cycle.
    wr_enable = 1'b1; W_addr = 5'd5; W_data = 32'hDEADBEEF; W_be = 4'hF;
    A_addr = 5'd5; B_addr = 5'd0;
    #3 reset = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    check("rst_mid.A0d_zero", a0_data, 32'd0);
    @(posedge clk);
    #1 idle();
    #1 reset = 1'b1;
    check_all("rst_rel");
    check("rst_rel.C0_zero", {26'd0, c0}, 32'd0);
    @(posedge clk); #1;

    // Byte-enable merge.
    wr_enable = 1'b1; W_addr = 5'd3; W_data = 32'h11223344; W_be = 4'hF; A_addr = 5'd3;
    cycle("be_full");
    W_data = 32'hAABBCCDD; W_be = 4'b0101;
    cycle("be_part");
    idle();
    #2 check("be.A0d", a0_data, 32'h11BB33DD);
    check("be.A1d", a1_data, 32'h11BB33DD);
    #1;
    @(posedge clk); #1;

    // Bypass versus registered read-after-write.
    wr_enable = 1'b1; W_addr = 5'd7; W_data = 32'hCAFEF00D; W_be = 4'hF; A_addr = 5'd7;
    #2 check("byp.A0d_same", a0_data, 32'hCAFEF00D);
    check("byp.A1d_old", a1_data, 32'h0);
    #(-0) cycle("byp");
    idle();
    #2 check("byp.A1d_next", a1_data, 32'hCAFEF00D);
    #1;
    @(posedge clk); #1;

    // Reserve sequence, reserve+write collision, flush.
    A_addr = 5'd9; rsv_enable = 1'b1;
    rsv_addr = 5'd4;  cycle("rsv4");  check("rsv.cnt1", {26'd0, c0}, 32'd1);
    rsv_addr = 5'd9;  cycle("rsv9");  check("rsv.cnt2", {26'd0, c0}, 32'd2);
    rsv_addr = 5'd12; cycle("rsv12"); check("rsv.cnt3", {26'd0, c0}, 32'd3);
    check("rsv.A0b9", {31'd0, a0_busy}, 32'd1);
    wr_enable = 1'b1; W_addr = 5'd9; W_data = 32'h12345678; W_be = 4'hF; rsv_addr = 5'd9;
    cycle("rsv_wr");
    check("rsv_wr.cnt", {26'd0, c0}, 32'd3);
    idle(); flush = 1'b1;
    cycle("flush");
    check("flush.cnt", {26'd0, c0}, 32'd0);
    idle();

    // Zero register ignores writes and reserves.
    A_addr = 5'd0; wr_enable = 1'b1; W_addr = 5'd0; W_data = 32'hFFFFFFFF; W_be = 4'hF;
    rsv_enable = 1'b1; rsv_addr = 5'd0;
    cycle("zero");
    idle();
    #2 check("zero.A0d", a0_data, 32'd0);
    check("zero.A0b", {31'd0, a0_busy}, 32'd0);
    check("zero.C0", {26'd0, c0}, 32'd0);
    #1 flush = 1'b1;
    @(posedge clk); model_edge(); #1 idle();

    // Fill and drain the scoreboard.
    for (int r = 1; r < 32; r++) begin
      rsv_enable = 1'b1; rsv_addr = 5'(r); A_addr = 5'(r); B_addr = 5'(r - 1);
      cycle("fill");
    end
    idle();
    #2 check("fill.C0", {26'd0, c0}, 32'd31);
    #1;
    for (int r = 1; r < 32; r++) begin
      wr_enable = 1'b1; W_be = 4'h0; W_addr = 5'(r); A_addr = 5'(r); B_addr = 5'(32 - r);
      cycle("drain");
    end
    idle();
    #2 check("drain.C0", {26'd0, c0}, 32'd0);
    #1;

    // Randomised traffic with one asynchronous reset pulse.
    for (int i = 0; i < 600; i++) begin
      W_addr     = 5'($urandom_range(0, 31));
      W_data     = $urandom;
      W_be       = 4'($urandom_range(0, 15));
      wr_enable  = ($urandom_range(0, 1) == 1);
      rsv_enable = ($urandom_range(0, 9) < 4);
      rsv_addr   = ($urandom_range(0, 3) == 0) ? W_addr : 5'($urandom_range(0, 31));
      flush      = ($urandom_range(0, 29) == 0);
      A_addr     = ($urandom_range(0, 3) == 0) ? W_addr : 5'($urandom_range(0, 31));
      B_addr     = ($urandom_range(0, 3) == 0) ? rsv_addr : 5'($urandom_range(0, 31));
      if (i == 300) begin
        #1 reset = 1'b0;
        model_reset();
        #1 check_all("rnd_rst");
        #1 reset = 1'b1;
        #1;
      end
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
